iram_arbiter: RTL and testbench

- Shares one single-port synchronous instruction RAM (1-cycle read latency) between two requesters: the CPU fetch port and the program loader, which does boot-time and debug writes/readback.
- Sequences boot: after reset the CPU is stalled while the loader fills IRAM. On `load_done` the block switches to RUN.
- In RUN, fetch has priority; a bounded-starvation rule guarantees the loader eventually gets the RAM.
- Sits between the fetch stage, the loader and the IRAM macro.

---
 rtl/iram_arbiter_pkg.sv | 12 +
 rtl/iram_arbiter_if.sv | 30 +++
 rtl/iram_arbiter_prio.sv | 31 +++
 rtl/iram_arbiter.sv | 99 +++++++++
 tb/tb_iram_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/iram_arbiter_pkg.sv
// Shared types and constants for the IRAM arbiter: FSM state encoding and
// starve-counter sizing.
package iram_arbiter_pkg;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_e;

  function automatic int clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/iram_arbiter_if.sv
// Fetch / loader / IRAM bus bundle; slave is the arbiter side, master the
// environment (fetch stage, loader, RAM macro).
interface iram_arbiter_if #(
  parameter int ADDR_WIDTH = iram_arbiter_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = iram_arbiter_pkg::DEF_DATA_WIDTH
);
  logic                  fetch_req, fetch_gnt, fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_rdata;
  logic                  load_req, load_we, load_gnt, load_valid;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_wdata, load_rdata;
  logic                  load_done, reboot, cpu_stall;
  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata,
           load_done, reboot, ram_rdata,
    output fetch_gnt, fetch_valid, fetch_rdata, load_gnt, load_valid, load_rdata,
           cpu_stall, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata,
           load_done, reboot, ram_rdata,
    input  fetch_gnt, fetch_valid, fetch_rdata, load_gnt, load_valid, load_rdata,
           cpu_stall, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/iram_arbiter_prio.sv
// Combinational grant selection: loader-only in BOOT, fetch-priority in RUN
// with the loader forced through once it has lost MAX_WAIT times in a row.
module iram_arbiter_prio
  import iram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int SW       = clog2(MAX_WAIT + 1)
) (
  input  state_e        state,
  input  logic          fetch_req,
  input  logic          load_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          fetch_gnt,
  output logic          load_gnt
);
  localparam logic [SW-1:0] MAXW = SW'(MAX_WAIT);

  logic starved;
  assign starved = (starve_cnt == MAXW);

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (state == ST_BOOT) begin
      load_gnt = load_req;
    end else begin
      load_gnt  = load_req & (~fetch_req | starved);
      fetch_gnt = fetch_req & ~load_gnt;
    end
  end
endmodule

// File: rtl/iram_arbiter.sv
// IRAM arbiter top: boot/run FSM, starve counter, read-valid registers and
// RAM mux. Optional perf counters behind IRAM_ARBITER_PERF_EN.
module iram_arbiter
  import iram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input  logic         clk,
  input  logic         nrst,
  iram_arbiter_if.slave bus
`ifdef IRAM_ARBITER_PERF_EN
  ,
  output logic [31:0]  perf_fetch_stall,
  output logic [31:0]  perf_load_wr
`endif
);
  localparam int            SW   = clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] MAXW = SW'(MAX_WAIT);

  state_e        state;
  logic [SW-1:0] starve_cnt;
  logic          cpu_stall_q, fetch_vld_q, load_vld_q;
  logic          fetch_gnt_raw, load_gnt_raw, fetch_gnt, load_gnt;

  iram_arbiter_prio #(.MAX_WAIT(MAX_WAIT), .SW(SW)) u_prio (
    .state     (state),
    .fetch_req (bus.fetch_req),
    .load_req  (bus.load_req),
    .starve_cnt(starve_cnt),
    .fetch_gnt (fetch_gnt_raw),
    .load_gnt  (load_gnt_raw)
  );

  // No access may reach the RAM while reset is asserted.
  assign fetch_gnt = nrst & fetch_gnt_raw;
  assign load_gnt  = nrst & load_gnt_raw;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_BOOT;
      starve_cnt  <= '0;
      cpu_stall_q <= 1'b1;
      fetch_vld_q <= 1'b0;
      load_vld_q  <= 1'b0;
    end else begin
      fetch_vld_q <= fetch_gnt;
      load_vld_q  <= load_gnt & ~bus.load_we;
      case (state)
        ST_BOOT: begin
          starve_cnt <= '0;
          if (bus.load_done && !bus.reboot) begin
            state       <= ST_RUN;
            cpu_stall_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.reboot) begin
            state       <= ST_BOOT;
            cpu_stall_q <= 1'b1;
            starve_cnt  <= '0;
          end else if (!bus.load_req || load_gnt) begin
            starve_cnt <= '0;
          end else if (starve_cnt != MAXW) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.fetch_gnt   = fetch_gnt;
  assign bus.load_gnt    = load_gnt;
  assign bus.cpu_stall   = cpu_stall_q;
  assign bus.fetch_valid = fetch_vld_q;
  assign bus.load_valid  = load_vld_q;
  assign bus.fetch_rdata = fetch_vld_q ? bus.ram_rdata : '0;
  assign bus.load_rdata  = load_vld_q  ? bus.ram_rdata : '0;

  assign bus.ram_en    = fetch_gnt | load_gnt;
  assign bus.ram_we    = load_gnt & bus.load_we;
  assign bus.ram_addr  = fetch_gnt ? bus.fetch_addr : (load_gnt ? bus.load_addr : '0);
  assign bus.ram_wdata = load_gnt ? bus.load_wdata : '0;

`ifdef IRAM_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_fetch_stall <= '0;
      perf_load_wr     <= '0;
    end else begin
      if (state == ST_RUN && bus.fetch_req && !fetch_gnt && perf_fetch_stall != '1)
        perf_fetch_stall <= perf_fetch_stall + 32'd1;
      if (load_gnt && bus.load_we && perf_load_wr != '1)
        perf_load_wr <= perf_load_wr + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_iram_arbiter.sv
// Directed bench for iram_arbiter with a behavioural reference model,
// a per-cycle compare process and literal checks on the scripted scenarios.
module tb_iram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  bit   done = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  iram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef IRAM_ARBITER_PERF_EN
  logic [31:0] perf_fetch_stall, perf_load_wr;
`endif

  iram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
`ifdef IRAM_ARBITER_PERF_EN
    ,
    .perf_fetch_stall(perf_fetch_stall),
    .perf_load_wr    (perf_load_wr)
`endif
  );

  // IRAM macro: one-cycle registered read.
  logic [DW-1:0] mem [512];
  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run flag, count of consecutive loader losses, pending
  // read results, and a shadow copy of the program image.
  bit            run;
  int            wait_n;
  bit            pf, pl;
  logic [DW-1:0] pf_d, pl_d;
  logic [DW-1:0] shadow [512];

  function automatic bit exp_lg();
    return nrst && bus.load_req && (!run || !bus.fetch_req || wait_n >= MW);
  endfunction
  function automatic bit exp_fg();
    return nrst && run && bus.fetch_req && !exp_lg();
  endfunction

  always @(posedge clk or negedge nrst)
    if (!nrst) begin
      run <= 0; wait_n <= 0; pf <= 0; pl <= 0;
    end else begin
      pf   <= exp_fg();
      pf_d <= shadow[bus.fetch_addr];
      pl   <= exp_lg() && !bus.load_we;
      pl_d <= shadow[bus.load_addr];
      if (exp_lg() && bus.load_we) shadow[bus.load_addr] <= bus.load_wdata;
      if (!run) begin
        wait_n <= 0;
        if (bus.load_done && !bus.reboot) run <= 1;
      end else if (bus.reboot) begin
        run <= 0; wait_n <= 0;
      end else if (bus.load_req && !exp_lg()) begin
        wait_n <= (wait_n < MW) ? wait_n + 1 : MW;
      end else begin
        wait_n <= 0;
      end
    end

  always @(negedge clk)
    if (!done) begin
      bit fg, lg;
      fg = exp_fg();
      lg = exp_lg();
      chk("fetch_gnt", bus.fetch_gnt, fg);
      chk("load_gnt", bus.load_gnt, lg);
      chk("ram_en", bus.ram_en, fg | lg);
      chk("ram_we", bus.ram_we, lg & bus.load_we);
      chk("ram_addr", bus.ram_addr, fg ? bus.fetch_addr : (lg ? bus.load_addr : '0));
      if (!fg) chk("ram_wdata", bus.ram_wdata, lg ? bus.load_wdata : '0);
      chk("fetch_valid", bus.fetch_valid, pf);
      chk("load_valid", bus.load_valid, pl);
      chk("fetch_rdata", bus.fetch_rdata, pf ? pf_d : '0);
      chk("load_rdata", bus.load_rdata, pl ? pl_d : '0);
      chk("cpu_stall", bus.cpu_stall, !run);
      chk("starve_cnt", 64'(dut.starve_cnt), 64'(wait_n));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] words [4];

  initial begin
    for (int i = 0; i < 512; i++) begin mem[i] = '0; shadow[i] = '0; end
    words[0] = 32'h8c010000; words[1] = 32'h8c020004;
    words[2] = 32'h8c030008; words[3] = 32'h8c04000c;
    bus.ram_rdata = '0;
    bus.fetch_req = 1; bus.fetch_addr = '0;
    bus.load_req = 0; bus.load_we = 0; bus.load_addr = '0; bus.load_wdata = '0;
    bus.load_done = 0; bus.reboot = 0;
    @(negedge clk);
    chk("rst_stall", bus.cpu_stall, 1);
    chk("rst_fgnt", bus.fetch_gnt, 0);
    tick(); tick();
    nrst = 1;

    // Boot load with fetch held requesting.
    for (int i = 0; i < 4; i++) begin
      bus.load_req = 1; bus.load_we = 1;
      bus.load_addr = AW'(i); bus.load_wdata = words[i];
      @(negedge clk);
      chk("boot_we", bus.ram_we, 1);
      chk("boot_fgnt", bus.fetch_gnt, 0);
      chk("boot_stall", bus.cpu_stall, 1);
      tick();
    end
    bus.load_req = 0; bus.load_we = 0; bus.load_done = 1; bus.fetch_addr = 9'd2;
    @(negedge clk);
    chk("done_stall", bus.cpu_stall, 1);
    tick();
    bus.load_done = 0;
    @(negedge clk);
    chk("run_stall", bus.cpu_stall, 0);
    chk("run_fgnt", bus.fetch_gnt, 1);
    chk("run_addr", bus.ram_addr, 2);
    tick();
    bus.fetch_req = 0;
    @(negedge clk);
    chk("run_fvalid", bus.fetch_valid, 1);
    chk("run_frdata", bus.fetch_rdata, 32'h8c030008);
    chk("run_lvalid", bus.load_valid, 0);
    tick();

    // Starvation: loader wins every fifth cycle; load_done must be ignored.
    bus.fetch_req = 1; bus.fetch_addr = '0;
    bus.load_req = 1; bus.load_we = 0; bus.load_addr = 9'd1;
    for (int i = 0; i < 10; i++) begin
      bus.load_done = (i == 2);
      @(negedge clk);
      chk("starve_lgnt", bus.load_gnt, (i % 5) == 4);
      tick();
    end
    bus.load_done = 0;

    // Loader readback with fetch idle.
    bus.fetch_req = 0; bus.load_addr = 9'd0;
    @(negedge clk);
    chk("rb_lgnt", bus.load_gnt, 1);
    tick();
    bus.load_req = 0;
    @(negedge clk);
    chk("rb_lvalid", bus.load_valid, 1);
    chk("rb_lrdata", bus.load_rdata, 32'h8c010000);
    chk("rb_fvalid", bus.fetch_valid, 0);
    tick();

    // Reboot coincident with a fetch grant.
    bus.fetch_req = 1; bus.fetch_addr = 9'd3; bus.reboot = 1;
    @(negedge clk);
    chk("rbt_fgnt", bus.fetch_gnt, 1);
    tick();
    bus.reboot = 0;
    @(negedge clk);
    chk("rbt_fvalid", bus.fetch_valid, 1);
    chk("rbt_frdata", bus.fetch_rdata, 32'h8c04000c);
    chk("rbt_stall", bus.cpu_stall, 1);
    chk("rbt_fgnt0", bus.fetch_gnt, 0);
    tick();
    bus.reboot = 1; bus.load_done = 1;
    tick();
    bus.reboot = 0; bus.load_done = 0;
    @(negedge clk);
    chk("rbt_wins", bus.cpu_stall, 1);
    chk("rbt_wins_fgnt", bus.fetch_gnt, 0);
    tick();
    bus.load_done = 1;
    tick();
    bus.load_done = 0; bus.fetch_addr = 9'd1;
    @(negedge clk);
    chk("rerun_stall", bus.cpu_stall, 0);
    chk("rerun_fgnt", bus.fetch_gnt, 1);

    // Async reset while the read is in flight.
    @(posedge clk);
    #2 nrst = 0;
    #1;
    chk("arst_fvalid", bus.fetch_valid, 0);
    chk("arst_stall", bus.cpu_stall, 1);
    chk("arst_fgnt", bus.fetch_gnt, 0);
    bus.fetch_req = 0;
    tick();
    nrst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_novalid", bus.fetch_valid, 0);
    end
    chk("arst_boot", bus.cpu_stall, 1);

    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
